// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared state encoding and sizing helpers for the UART TX arbiter
package uart_tx_arb_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_ACK, WAIT_DONE} arb_state_t;

    localparam logic [7:0] HDR_BASE_DEFAULT = 8'hA0;

    function automatic int BYTES_PER_WORD(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap-around
module rr_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    logic [N-1:0] rot;

    // rot[k] is the request sitting k places above ptr
    assign rot = N'({req, req} >> ptr);

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = N - 1; k >= 0; k--)
            if (rot[k]) begin
                gnt_idx = PW'((int'(ptr) + k) % N);
                any     = 1'b1;
            end
    end

    assign gnt = any ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART byte transmitter between NUM_REQ producers,
// sending a source header byte followed by the granted word LSB first.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int         NUM_REQ  = 4,
    parameter int         DATA_W   = 16,
    parameter logic [7:0] HDR_BASE = HDR_BASE_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    input  logic                      tx_busy,
    output logic                      tx_start,
    output logic [7:0]                tx_data,
    output logic                      busy
);

    localparam int BPW = BYTES_PER_WORD(DATA_W);
    localparam int CW  = $clog2(BPW + 1);
    localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t          state_q, state_d;
    logic [PW-1:0]       rr_ptr, idx_q, win_idx;
    logic [NUM_REQ-1:0]  win_gnt;
    logic                win_any;
    logic [DATA_W-1:0]   word_q, win_word;
    logic [CW-1:0]       byte_cnt;
    logic                capture, load_hdr, load_byte, last_byte;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (win_gnt),
        .gnt_idx (win_idx),
        .any     (win_any)
    );

    always_comb begin
        win_word = '0;
        for (int i = 0; i < NUM_REQ; i++)
            win_word |= win_gnt[i] ? req_data[i*DATA_W +: DATA_W] : '0;
    end

    assign last_byte = byte_cnt == CW'(BPW);

    always_ff @(posedge clk) begin
        state_q <= reset ? IDLE : state_d;
    end

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        load_hdr  = 1'b0;
        load_byte = 1'b0;
        grant     = '0;
        tx_start  = 1'b0;
        busy      = state_q != IDLE;
        unique case (state_q)
            IDLE: begin
                capture = win_any;
                state_d = win_any ? LOAD : IDLE;
            end
            LOAD: begin
                grant    = NUM_REQ'(1) << idx_q;
                load_hdr = 1'b1;
                state_d  = SEND;
            end
            // a byte from before this frame (or before a reset) may still be draining
            SEND: begin
                tx_start = !tx_busy;
                state_d  = tx_busy ? SEND : WAIT_ACK;
            end
            WAIT_ACK: state_d = tx_busy ? WAIT_DONE : WAIT_ACK;
            WAIT_DONE: begin
                load_byte = !tx_busy && !last_byte;
                state_d   = tx_busy ? WAIT_DONE : (last_byte ? IDLE : SEND);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr   <= '0;
            idx_q    <= '0;
            word_q   <= '0;
            byte_cnt <= '0;
            tx_data  <= 8'h00;
        end else begin
            if (capture) begin
                word_q <= win_word;
                idx_q  <= win_idx;
                rr_ptr <= PW'((int'(win_idx) + 1) % NUM_REQ);
            end
            if (load_hdr) begin
                tx_data  <= HDR_BASE | 8'(idx_q);
                byte_cnt <= '0;
            end
            if (load_byte) begin
                tx_data  <= 8'(word_q >> {byte_cnt, 3'b000});
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized and directed scoreboard bench; a frame-level model predicts
// the winner and byte stream at each grant, a monitor pops expectations on every tx_start.
module tb_uart_tx_arbiter;

    localparam int         N   = 4;
    localparam int         W   = 16;
    localparam int         BPW = W / 8;
    localparam int         IW  = $clog2(N);
    localparam logic [7:0] HDR = 8'hA0;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [N-1:0]        req = '0;
    logic [N-1:0]        sticky = '0;
    logic [N-1:0][W-1:0] data = '0;
    logic [N-1:0]        grant;
    logic                tx_start, busy, tx_busy;
    logic [7:0]          tx_data;
    logic                hold = 1'b0;
    int                  ucnt = 0;

    int checks = 0, errors = 0, starts = 0;

    logic [N-1:0]        req_seen = '0;
    logic [N-1:0][W-1:0] data_seen = '0;
    logic                rst_seen = 1'b1;
    logic [7:0]          exp_q[$];
    int                  last = N - 1;
    int                  win;
    logic                start_prev = 1'b0, busy_prev = 1'b0, start_due = 1'b0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .HDR_BASE(HDR)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (data),
        .grant    (grant),
        .tx_busy  (tx_busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .busy     (busy)
    );

    // UART model: busy from the cycle after tx_start for 10 cycles; hold forces it high
    assign tx_busy = (ucnt != 0) || hold;

    always @(posedge clk) begin
        ucnt      <= tx_start ? 10 : (ucnt != 0 ? ucnt - 1 : 0);
        req_seen  <= req;
        data_seen <= data;
        rst_seen  <= reset;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // requester last served gets lowest priority: search upward from the one after it
    function automatic int pick(input logic [N-1:0] r, input int from);
        for (int k = 1; k <= N; k++)
            if (r[IW'((from + k) % N)]) return (from + k) % N;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst_seen) begin
            check("rst_busy", int'(busy), 0);
            check("rst_tx_start", int'(tx_start), 0);
            check("rst_tx_data", int'(tx_data), 0);
            check("rst_grant", int'(grant), 0);
            exp_q.delete();
            last       = N - 1;
            start_prev = 1'b0;
            busy_prev  = 1'b0;
            start_due  = 1'b0;
        end else begin
            if (start_due) check("start_latency", int'(tx_start), 1);
            start_due = 1'b0;
            if (grant != 0) begin
                win = pick(req_seen, last);
                check("grant", int'(grant), win < 0 ? 0 : 1 << win);
                check("grant_busy", int'(busy), 1);
                check("idle_gap", int'(busy_prev), 0);
                check("frame_overlap", exp_q.size(), 0);
                if (win >= 0) begin
                    exp_q.push_back(HDR | 8'(win));
                    for (int b = 0; b < BPW; b++)
                        exp_q.push_back(8'(data_seen[IW'(win)] >> (8 * b)));
                    last = win;
                end
                start_due = !tx_busy;
            end
            if (tx_start) begin
                check("start_while_tx_busy", int'(tx_busy), 0);
                check("start_twice", int'(start_prev), 0);
                check("start_busy", int'(busy), 1);
                check("tx_byte_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
            end
            if (busy_prev && !busy) check("frame_bytes_left", exp_q.size(), 0);
            start_prev = tx_start;
            busy_prev  = busy;
        end
    end

    // one cycle; a granted requester drops req (unless sticky) and scrambles its word
    task automatic tick();
        @(negedge clk);
        if (tx_start) starts++;
        for (int i = 0; i < N; i++)
            if (grant[i]) data[i] = W'($urandom);
        req = req & ~(grant & ~sticky);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_quiet(input int max);
        int n = 0;
        while (n < max && (req != 0 || busy || tx_busy)) begin
            tick();
            n++;
        end
        check("quiet_timeout", int'({req, busy, tx_busy}), 0);
    endtask

    task automatic wait_grant(input int max);
        int n = 0;
        do begin
            tick();
            n++;
        end while (grant == 0 && n < max);
        check("grant_timeout", int'(grant != 0), 1);
    endtask

    task automatic wait_starts(input int k, input int max);
        int target = starts + k;
        int n = 0;
        while (starts < target && n < max) begin
            tick();
            n++;
        end
        check("start_timeout", int'(starts >= target), 1);
    endtask

    initial begin
        logic [N-1:0] nr;
        int s0;
        do_reset();
        data[2] = 16'hBEEF;
        req[2]  = 1'b1;
        tick();
        check("single_grant_cycle1", int'(grant), 4);
        wait_quiet(200);

        do_reset();
        for (int i = 0; i < N; i++) data[i] = W'($urandom);
        req = '1;
        wait_quiet(600);

        do_reset();
        sticky  = 4'b0010;
        data[1] = W'($urandom);
        req[1]  = 1'b1;
        wait_grant(20);
        repeat (5) tick();
        data[3] = W'($urandom);
        req[3]  = 1'b1;
        wait_grant(200);
        check("fair_next", int'(grant), 8);
        wait_grant(200);
        check("fair_then", int'(grant), 2);
        sticky = '0;
        wait_quiet(300);

        hold    = 1'b1;
        data[3] = W'($urandom);
        req[3]  = 1'b1;
        s0      = starts;
        repeat (15) tick();
        check("held_no_start", starts - s0, 0);
        hold = 1'b0;
        wait_quiet(200);

        do_reset();
        data[2] = W'($urandom);
        req[2]  = 1'b1;
        wait_grant(20);
        data[0] = W'($urandom);
        req[0]  = 1'b1;
        wait_starts(3, 200);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        wait_grant(50);
        check("after_reset_grant", int'(grant), 1);
        wait_quiet(300);

        do_reset();
        for (int it = 0; it < 60; it++) begin
            nr = N'($urandom);
            for (int i = 0; i < N; i++)
                if (nr[i] && !req[i]) data[i] = W'($urandom);
            req = req | nr;
            repeat ($urandom_range(1, 50)) tick();
        end
        wait_quiet(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
